// File: rtl/dram_arb_pkg.sv
// Shared types and default widths for the DRAM arbiter, the cache ports and the DRAM CDC buffer.
package dram_arb_pkg;

    localparam int DRAM_NUM_REQ     = 2;
    localparam int DRAM_ADDR_W      = 27;
    localparam int DRAM_DATA_W      = 128;
    localparam int DRAM_OUTSTANDING = 4;
    localparam int REQ_ID_W         = (DRAM_NUM_REQ > 1) ? $clog2(DRAM_NUM_REQ) : 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic [DRAM_ADDR_W-1:0] addr;
        logic                   we;
        logic [DRAM_DATA_W-1:0] wdata;
    } dram_req_t;

endpackage

// File: rtl/dram_arb_order_fifo.sv
// In-order requester-ID queue for outstanding DRAM reads; head names the owner of the next response.
module dram_arb_order_fifo
    import dram_arb_pkg::*;
#(
    parameter int DEPTH = DRAM_OUTSTANDING,
    parameter int ID_W  = $bits(req_id_t)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           push,
    input  logic [ID_W-1:0]                push_id,
    input  logic                           pop,
    output logic [ID_W-1:0]                head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates NUM_REQ cache requesters onto one DRAM request/response channel with in-order read routing.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default build is round-robin.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ     = DRAM_NUM_REQ,
    parameter int ADDR_W      = DRAM_ADDR_W,
    parameter int DATA_W      = DRAM_DATA_W,
    parameter int OUTSTANDING = DRAM_OUTSTANDING
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_REQ-1:0]                 up_req_en,
    input  logic [NUM_REQ*ADDR_W-1:0]          up_req_addr,
    input  logic [NUM_REQ-1:0]                 up_req_we,
    input  logic [NUM_REQ*DATA_W-1:0]          up_req_wdata,
    output logic [NUM_REQ-1:0]                 up_req_rdy,
    output logic [NUM_REQ-1:0]                 up_rsp_en,
    output logic [DATA_W-1:0]                  up_rsp_data,
    input  logic [NUM_REQ-1:0]                 up_rsp_rdy,
    output logic                               dn_req_en,
    output logic [ADDR_W-1:0]                  dn_req_addr,
    output logic                               dn_req_we,
    output logic [DATA_W-1:0]                  dn_req_wdata,
    input  logic                               dn_req_rdy,
    input  logic                               dn_rsp_en,
    input  logic [DATA_W-1:0]                  dn_rsp_data,
    output logic                               dn_rsp_rdy,
    output logic [$clog2(OUTSTANDING+1)-1:0]   rd_inflight,
    output logic                               proto_err
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    logic               loadable;
    logic               grant;
    logic [ID_W-1:0]    winner;
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    head_id;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    dram_req_t          win_req;
    dram_req_t          dn_req_q;

    assign loadable = !dn_req_en || dn_req_rdy;

    // Writes bypass the order queue, so only reads are held back when it is full.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = up_req_en[i] && (up_req_we[i] || (rd_inflight < CNT_W'(OUTSTANDING)));
        end
    end

`ifdef DRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant  = 1'b1;
                winner = ID_W'(i);
            end
        end
        if (!loadable || !rstn) begin
            grant = 1'b0;
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;

    // Scan backwards so the first eligible index after rr_ptr is the last one assigned.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant  = 1'b1;
                winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        if (!loadable || !rstn) begin
            grant = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (grant) begin
            rr_ptr <= winner;
        end
    end
`endif

    always_comb begin
        up_req_rdy = '0;
        if (grant) begin
            up_req_rdy[winner] = 1'b1;
        end
    end

    always_comb begin
        win_req.addr  = up_req_addr[int'(winner)*ADDR_W +: ADDR_W];
        win_req.we    = up_req_we[winner];
        win_req.wdata = up_req_wdata[int'(winner)*DATA_W +: DATA_W];
    end

    assign push = grant && !up_req_we[winner];

    // An empty queue still accepts responses so a stray beat drains instead of wedging DRAM.
    always_comb begin
        up_rsp_en  = '0;
        dn_rsp_rdy = 1'b1;
        if (!fifo_empty) begin
            dn_rsp_rdy         = up_rsp_rdy[head_id];
            up_rsp_en[head_id] = dn_rsp_en && rstn;
        end
    end

    assign pop         = dn_rsp_en && dn_rsp_rdy && !fifo_empty;
    assign up_rsp_data = dn_rsp_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dn_req_en <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (loadable) begin
                dn_req_en <= grant;
            end
            if (dn_rsp_en && fifo_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            dn_req_q <= win_req;
        end
    end

    assign dn_req_addr  = dn_req_q.addr;
    assign dn_req_we    = dn_req_q.we;
    assign dn_req_wdata = dn_req_q.wdata;

    dram_arb_order_fifo #(
        .DEPTH (OUTSTANDING),
        .ID_W  (ID_W)
    ) u_order_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .head    (head_id),
        .count   (rd_inflight),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: reference model pushes expected downstream requests and responses.
// Honours DRAM_ARB_FIXED_PRIO_EN the same way as the design.
module tb_dram_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int ADDR_W      = 27;
    localparam int DATA_W      = 128;
    localparam int OUTSTANDING = 4;
    localparam int CNT_W       = $clog2(OUTSTANDING + 1);

    localparam int M_RESET = 0;
    localparam int M_STRAY = 1;
    localparam int M_FAIR  = 2;
    localparam int M_WFULL = 3;
    localparam int M_BP    = 4;
    localparam int M_RAND  = 5;
    localparam int M_DRAIN = 6;

    logic                       clk = 1'b0;
    logic                       rstn;
    logic [NUM_REQ-1:0]         up_req_en;
    logic [NUM_REQ*ADDR_W-1:0]  up_req_addr;
    logic [NUM_REQ-1:0]         up_req_we;
    logic [NUM_REQ*DATA_W-1:0]  up_req_wdata;
    logic [NUM_REQ-1:0]         up_req_rdy;
    logic [NUM_REQ-1:0]         up_rsp_en;
    logic [DATA_W-1:0]          up_rsp_data;
    logic [NUM_REQ-1:0]         up_rsp_rdy;
    logic                       dn_req_en;
    logic [ADDR_W-1:0]          dn_req_addr;
    logic                       dn_req_we;
    logic [DATA_W-1:0]          dn_req_wdata;
    logic                       dn_req_rdy;
    logic                       dn_rsp_en;
    logic [DATA_W-1:0]          dn_rsp_data;
    logic                       dn_rsp_rdy;
    logic [CNT_W-1:0]           rd_inflight;
    logic                       proto_err;

    always #5 clk = ~clk;

    dram_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .up_req_en    (up_req_en),
        .up_req_addr  (up_req_addr),
        .up_req_we    (up_req_we),
        .up_req_wdata (up_req_wdata),
        .up_req_rdy   (up_req_rdy),
        .up_rsp_en    (up_rsp_en),
        .up_rsp_data  (up_rsp_data),
        .up_rsp_rdy   (up_rsp_rdy),
        .dn_req_en    (dn_req_en),
        .dn_req_addr  (dn_req_addr),
        .dn_req_we    (dn_req_we),
        .dn_req_wdata (dn_req_wdata),
        .dn_req_rdy   (dn_req_rdy),
        .dn_rsp_en    (dn_rsp_en),
        .dn_rsp_data  (dn_rsp_data),
        .dn_rsp_rdy   (dn_rsp_rdy),
        .rd_inflight  (rd_inflight),
        .proto_err    (proto_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } exp_req_t;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
    } exp_rsp_t;

    exp_req_t          dn_exp_q[$];
    exp_rsp_t          rsp_exp_q[$];
    logic [ADDR_W-1:0] dram_pending[$];
    int                m_order[$];

    int  vectors     = 0;
    int  miscompares = 0;
    int  n_checks    = 0;

    int  m_ptr       = NUM_REQ - 1;
    bit  m_out_full  = 1'b0;
    bit  m_proto     = 1'b0;
    bit  prev_rstn   = 1'b1;
    bit  granted [NUM_REQ];
    bit  req_pending [NUM_REQ];
    logic [ADDR_W-1:0] req_addr  [NUM_REQ];
    logic              req_we    [NUM_REQ];
    logic [DATA_W-1:0] req_wdata [NUM_REQ];
    bit  rsp_accepted = 1'b0;

    bit                hold_valid = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_we;
    logic [DATA_W-1:0] hold_wdata;

    // DRAM read data is a fixed function of the address so the scoreboard can predict it.
    function automatic logic [DATA_W-1:0] rsp_data(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {5'b0, a} ^ 32'hA5A5_0000;
        return {w, ~w, w + 32'd1, w ^ 32'h1234_5678};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: arbitration and queue bookkeeping from the rules, evaluated mid-cycle.
    int                m_win;
    int                m_cand;
    bit                m_loadable;
    logic [NUM_REQ-1:0] m_exp_rdy;
    exp_req_t          m_req;
    exp_rsp_t          m_rsp;

    always begin
        @(negedge clk);
        #1;
        if (!rstn) begin
            checkOutput("up_req_rdy_in_reset", 128'(up_req_rdy), 128'(0));
            checkOutput("up_rsp_en_in_reset", 128'(up_rsp_en), 128'(0));
            if (!prev_rstn) begin
                checkOutput("dn_req_en_reset", 128'(dn_req_en), 128'(0));
                checkOutput("rd_inflight_reset", 128'(rd_inflight), 128'(0));
                checkOutput("proto_err_reset", 128'(proto_err), 128'(0));
            end
            m_ptr      = NUM_REQ - 1;
            m_out_full = 1'b0;
            m_proto    = 1'b0;
            dn_exp_q.delete();
            rsp_exp_q.delete();
            dram_pending.delete();
            m_order.delete();
            for (int i = 0; i < NUM_REQ; i++) granted[i] = 1'b0;
        end else begin
            checkOutput("dn_req_en", 128'(dn_req_en), 128'(m_out_full));
            checkOutput("rd_inflight", 128'(rd_inflight), 128'(m_order.size()));
            checkOutput("proto_err", 128'(proto_err), 128'(m_proto));

            m_loadable = !m_out_full || dn_req_rdy;
            m_win = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
                m_cand = k;
`else
                m_cand = (m_ptr + 1 + k) % NUM_REQ;
`endif
                if (m_win < 0 && up_req_en[m_cand] &&
                    (up_req_we[m_cand] || m_order.size() < OUTSTANDING)) begin
                    m_win = m_cand;
                end
            end
            if (!m_loadable) m_win = -1;
            m_exp_rdy = '0;
            if (m_win >= 0) m_exp_rdy[m_win] = 1'b1;
            checkOutput("up_req_rdy", 128'(up_req_rdy), 128'(m_exp_rdy));

            if (dn_rsp_en) begin
                if (m_order.size() == 0) m_proto = 1'b1;
                else if (up_rsp_rdy[m_order[0]]) void'(m_order.pop_front());
            end

            if (m_win >= 0) begin
                m_req.addr  = up_req_addr[m_win*ADDR_W +: ADDR_W];
                m_req.we    = up_req_we[m_win];
                m_req.wdata = up_req_wdata[m_win*DATA_W +: DATA_W];
                dn_exp_q.push_back(m_req);
                if (!m_req.we) begin
                    m_order.push_back(m_win);
                    m_rsp.id   = m_win;
                    m_rsp.data = rsp_data(m_req.addr);
                    rsp_exp_q.push_back(m_rsp);
                end
                m_ptr = m_win;
                granted[m_win] = 1'b1;
            end
            if (m_loadable) m_out_full = (m_win >= 0);
        end
        prev_rstn = rstn;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a downstream request or a response.
    exp_req_t           mon_req;
    exp_rsp_t           mon_rsp;
    logic [NUM_REQ-1:0] mon_en;

    always @(negedge clk) begin
        if (!rstn) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                checkOutput("dn_req_en_held", 128'(dn_req_en), 128'(1));
                checkOutput("dn_req_addr_held", 128'(dn_req_addr), 128'(hold_addr));
                checkOutput("dn_req_we_held", 128'(dn_req_we), 128'(hold_we));
                checkOutput("dn_req_wdata_held", 128'(dn_req_wdata), 128'(hold_wdata));
            end
            hold_valid = dn_req_en && !dn_req_rdy;
            hold_addr  = dn_req_addr;
            hold_we    = dn_req_we;
            hold_wdata = dn_req_wdata;

            if (dn_req_en && dn_req_rdy) begin
                if (dn_exp_q.size() == 0) begin
                    n_checks++;
                    miscompares++;
                    $display("[TB] FAIL dn_req_unexpected: got request addr %0h, expected none at %0t",
                             dn_req_addr, $time);
                end else begin
                    mon_req = dn_exp_q.pop_front();
                    checkOutput("dn_req_addr", 128'(dn_req_addr), 128'(mon_req.addr));
                    checkOutput("dn_req_we", 128'(dn_req_we), 128'(mon_req.we));
                    checkOutput("dn_req_wdata", 128'(dn_req_wdata), 128'(mon_req.wdata));
                end
                if (!dn_req_we) dram_pending.push_back(dn_req_addr);
            end

            if (dn_rsp_en) begin
                if (rsp_exp_q.size() == 0) begin
                    checkOutput("stray_dn_rsp_rdy", 128'(dn_rsp_rdy), 128'(1));
                    checkOutput("stray_up_rsp_en", 128'(up_rsp_en), 128'(0));
                end else begin
                    mon_rsp = rsp_exp_q[0];
                    mon_en = '0;
                    mon_en[mon_rsp.id] = 1'b1;
                    checkOutput("up_rsp_en", 128'(up_rsp_en), 128'(mon_en));
                    checkOutput("up_rsp_data", 128'(up_rsp_data), 128'(mon_rsp.data));
                    checkOutput("dn_rsp_rdy", 128'(dn_rsp_rdy), 128'(up_rsp_rdy[mon_rsp.id]));
                    if (dn_rsp_rdy) begin
                        void'(rsp_exp_q.pop_front());
                        if (dram_pending.size() > 0) void'(dram_pending.pop_front());
                    end
                end
                rsp_accepted = dn_rsp_rdy;
            end else begin
                checkOutput("up_rsp_en_idle", 128'(up_rsp_en), 128'(0));
            end
        end
    end

    task automatic newRequest(input int i, input logic we);
        req_pending[i] = 1'b1;
        req_we[i]      = we;
        req_addr[i]    = ADDR_W'($urandom());
        req_wdata[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic applyStimulus(input int md, input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            vectors++;
            rstn = (md != M_RESET);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (granted[i]) begin
                    req_pending[i] = 1'b0;
                    granted[i]     = 1'b0;
                end
                if (md == M_RESET) begin
                    req_pending[i] = 1'b0;
                end else if (!req_pending[i]) begin
                    case (md)
                        M_FAIR:  newRequest(i, 1'b0);
                        M_WFULL: newRequest(i, (i == 0));
                        M_RAND:  if ($urandom_range(0, 99) < 60) newRequest(i, ($urandom_range(0, 99) < 30));
                        default: ;
                    endcase
                end
                up_req_en[i]                       = (md == M_RESET) ? 1'b1 : req_pending[i];
                up_req_we[i]                       = (md == M_RESET) ? 1'b0 : req_we[i];
                up_req_addr[i*ADDR_W +: ADDR_W]    = req_addr[i];
                up_req_wdata[i*DATA_W +: DATA_W]   = req_wdata[i];
            end

            dn_req_rdy = (md == M_BP) ? 1'b0 : (md == M_RAND) ? ($urandom_range(0, 99) < 70) : 1'b1;
            up_rsp_rdy = (md == M_BP) ? '0 : (md == M_RAND) ? NUM_REQ'($urandom()) | NUM_REQ'($urandom()) : '1;

            if (md == M_STRAY) begin
                dn_rsp_en   = 1'b1;
                dn_rsp_data = {4{32'hDEAD_BEEF}};
            end else if (md == M_BP || md == M_RAND || md == M_DRAIN) begin
                if (dn_rsp_en && !rsp_accepted) begin
                    dn_rsp_en = 1'b1;
                end else if (dram_pending.size() > 0 && (md == M_DRAIN || $urandom_range(0, 99) < 50)) begin
                    dn_rsp_en   = 1'b1;
                    dn_rsp_data = rsp_data(dram_pending[0]);
                end else begin
                    dn_rsp_en = 1'b0;
                end
            end else begin
                dn_rsp_en = 1'b0;
            end
        end
    endtask

    bit drained;

    initial begin
        rstn         = 1'b0;
        up_req_en    = '1;
        up_req_we    = '0;
        up_req_addr  = '0;
        up_req_wdata = '0;
        up_rsp_rdy   = '1;
        dn_req_rdy   = 1'b1;
        dn_rsp_en    = 1'b0;
        dn_rsp_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pending[i] = 1'b0;
            granted[i]     = 1'b0;
            req_addr[i]    = '0;
            req_we[i]      = 1'b0;
            req_wdata[i]   = '0;
        end

        applyStimulus(M_RESET, 3);
        applyStimulus(M_STRAY, 2);
        applyStimulus(M_RESET, 2);
        applyStimulus(M_RESET, 1);
        applyStimulus(M_FAIR, 8);
        applyStimulus(M_WFULL, 4);
        applyStimulus(M_BP, 5);
        applyStimulus(M_RAND, 1500);
        applyStimulus(M_RESET, 2);
        applyStimulus(M_RAND, 1500);

        drained = 1'b0;
        for (int c = 0; c < 300 && !drained; c++) begin
            applyStimulus(M_DRAIN, 1);
            @(negedge clk);
            #2;
            drained = !req_pending[0] && !req_pending[1] && (dn_exp_q.size() == 0) &&
                      (rsp_exp_q.size() == 0) && (m_order.size() == 0) && !dn_req_en;
        end
        n_checks++;
        if (!drained) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d requests and %0d responses outstanding, expected 0",
                     dn_exp_q.size(), rsp_exp_q.size());
        end
        applyStimulus(M_DRAIN, 3);
        @(negedge clk);
        #2;

        $display("[TB] %0d comparisons made", n_checks);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
